// File: rtl/instr_fetch_unit.sv
// Fetch stage between the PC and a synchronous instruction ROM, with a 2-entry {pc, word} buffer for the decoder.
// Define FETCH_PERF_EN to add the saturating fetch_cnt / flush_cnt performance counters.
module instr_fetch_unit #(
    parameter int IW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_addr,
    input  logic          jmp,
    output logic          pc_stall,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] ir_out,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   flush_cnt
`endif
);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] word;
    } entry_t;

    entry_t        mem_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] occupancy;

    assign imem_addr = pc_addr;
    assign ir_valid  = (count_q != 2'd0);
    assign ir_out    = mem_q[rd_ptr_q].word;
    assign ir_pc     = mem_q[rd_ptr_q].pc;

    assign pop  = ir_valid & ir_ready & ~jmp;
    assign push = pend_q & ~jmp;

    // Occupancy counts the in-flight word too, so a slot is always reserved for it.
    assign occupancy = count_q + {1'b0, pend_q} - {1'b0, pop};
    assign pc_stall  = occupancy[1];
    assign issue     = ~pc_stall & ~jmp;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pend_d    = 1'b0;
        pend_pc_d = pend_pc_q;

        if (jmp) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        if (issue) begin
            pend_d    = 1'b1;
            pend_pc_d = pc_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // NOTE: the buffer is only two entries, so it is reset so that ir_out/ir_pc read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: pend_pc_q, word: imem_data};
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (push && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (jmp && flush_cnt_q != 16'hFFFF)  flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
